// File: rtl/ln_pkg.sv
// Shared types and helpers for the LayerNorm statistics front-end.
package ln_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Signed channel-sum width: holds MAX_CH worst-case elements without wrap.
  function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned max_ch);
    return data_w + $clog2(max_ch);
  endfunction

  // Unsigned square-sum width: (-2^(DATA_W-1))^2 fits in 2*DATA_W bits.
  function automatic int unsigned sq_w(input int unsigned data_w, input int unsigned max_ch);
    return 2 * data_w + $clog2(max_ch);
  endfunction

  // Runtime frame configuration check.
  function automatic logic cfg_ok(input int unsigned ch, input int unsigned tok,
                                  input int unsigned max_ch, input int unsigned lanes);
    return (ch != 0) && (ch <= max_ch) && ((ch % lanes) == 0) && (tok != 0);
  endfunction

endpackage

// File: rtl/ln_lane_reduce.sv
// Combinational per-beat reduction: sign-extended lane sum and sum of lane squares.
module ln_lane_reduce #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned LANES  = 1
) (
  input  logic [LANES*DATA_W-1:0]                  data,
  output logic signed [DATA_W+$clog2(LANES)-1:0]   beat_sum,
  output logic [2*DATA_W+$clog2(LANES)-1:0]        beat_sq
);

  localparam int unsigned BS_W = DATA_W + $clog2(LANES);
  localparam int unsigned BQ_W = 2 * DATA_W + $clog2(LANES);

  logic signed [DATA_W-1:0]   lane;
  logic signed [2*DATA_W-1:0] lane_x;
  logic signed [2*DATA_W-1:0] lane_sq;

  // Accumulate every lane; squares are exact and non-negative in 2*DATA_W bits.
  always_comb begin
    beat_sum = '0;
    beat_sq  = '0;
    lane     = '0;
    lane_x   = '0;
    lane_sq  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane     = data[i*DATA_W +: DATA_W];
      lane_x   = (2*DATA_W)'(lane);
      lane_sq  = lane_x * lane_x;
      beat_sum = beat_sum + BS_W'(lane);
      beat_sq  = beat_sq + BQ_W'(unsigned'(lane_sq));
    end
  end

endmodule

// File: rtl/layernorm_stats_acc.sv
// Per-token channel sum / sum-of-squares accumulator feeding LayerNorm.
module layernorm_stats_acc import ln_pkg::*; #(
  parameter int unsigned DATA_W  = 19,
  parameter int unsigned LANES   = 1,
  parameter int unsigned MAX_CH  = 1024,
  parameter int unsigned MAX_TOK = 32'd1048575
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [$clog2(MAX_CH+1)-1:0]            Channel_Nums,
  input  logic [$clog2(MAX_TOK+1)-1:0]           Token_Nums,
  input  logic [LANES*DATA_W-1:0]                sData,
  input  logic                                   sValid,
  output logic                                   sReady,
  output logic                                   mData_valid,
  input  logic                                   mData_ready,
  output logic signed [sum_w(DATA_W, MAX_CH)-1:0] mSum,
  output logic [sq_w(DATA_W, MAX_CH)-1:0]        mSumSq,
  output logic                                   mLast,
  output logic                                   busy,
  output logic                                   cfg_err
);

  localparam int unsigned SUM_W = sum_w(DATA_W, MAX_CH);
  localparam int unsigned SQ_W  = sq_w(DATA_W, MAX_CH);
  localparam int unsigned CH_W  = $clog2(MAX_CH + 1);
  localparam int unsigned TOK_W = $clog2(MAX_TOK + 1);
  localparam int unsigned LOG_L = $clog2(LANES);
  localparam int unsigned BS_W  = DATA_W + LOG_L;
  localparam int unsigned BQ_W  = 2 * DATA_W + LOG_L;

  state_t                   state;
  logic [CH_W-1:0]          beats_per_tok;
  logic [CH_W-1:0]          beat_cnt;
  logic [TOK_W-1:0]         tok_total;
  logic [TOK_W-1:0]         tok_cnt;
  logic signed [SUM_W-1:0]  acc_sum;
  logic [SQ_W-1:0]          acc_sq;

  logic signed [BS_W-1:0]   beat_sum;
  logic [BQ_W-1:0]          beat_sq;
  logic                     beat_fire;
  logic                     last_beat;
  logic                     last_tok;
  logic                     out_hs;

  ln_lane_reduce #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_reduce (
    .data     (sData),
    .beat_sum (beat_sum),
    .beat_sq  (beat_sq)
  );

  // Input acceptance stalls whenever a held result has not been taken.
  assign sReady    = (state == ACC) && (!mData_valid || mData_ready);
  assign beat_fire = sValid && sReady;
  assign out_hs    = mData_valid && mData_ready;
  assign last_beat = (beat_cnt == beats_per_tok - CH_W'(1));
  assign last_tok  = (tok_cnt == tok_total - TOK_W'(1));

  // FSM, counters, accumulators and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      beats_per_tok <= '0;
      beat_cnt      <= '0;
      tok_total     <= '0;
      tok_cnt       <= '0;
      acc_sum       <= '0;
      acc_sq        <= '0;
      mData_valid   <= 1'b0;
      mSum          <= '0;
      mSumSq        <= '0;
      mLast         <= 1'b0;
      busy          <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (out_hs) begin
        mData_valid <= 1'b0;
        mLast       <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok(32'(Channel_Nums), 32'(Token_Nums), MAX_CH, LANES)) begin
              beats_per_tok <= Channel_Nums >> LOG_L;
              tok_total     <= Token_Nums;
              beat_cnt      <= '0;
              tok_cnt       <= '0;
              acc_sum       <= '0;
              acc_sq        <= '0;
              busy          <= 1'b1;
              state         <= ACC;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ACC: begin
          if (beat_fire) begin
            if (last_beat) begin
              mSum        <= acc_sum + SUM_W'(beat_sum);
              mSumSq      <= acc_sq + SQ_W'(beat_sq);
              mData_valid <= 1'b1;
              mLast       <= last_tok;
              acc_sum     <= '0;
              acc_sq      <= '0;
              beat_cnt    <= '0;
              tok_cnt     <= tok_cnt + TOK_W'(1);
              if (last_tok) begin
                state <= DRAIN;
              end
            end else begin
              acc_sum  <= acc_sum + SUM_W'(beat_sum);
              acc_sq   <= acc_sq + SQ_W'(beat_sq);
              beat_cnt <= beat_cnt + CH_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/layernorm_stats_acc.md
# layernorm_stats_acc

Parametrised per-token statistics front-end for the LayerNorm datapath. It consumes a quantised activation stream of Token_Nums tokens × Channel_Nums channels, LANES channels per beat. For each token it emits the channel sum and sum of squares that the normalisation stage turns into mean and variance. It generalises the single-lane, fixed 19-bit LayerNorm input path to configurable data width, lane count and maximum channel count, and adds runtime configuration checking.

## Interface
Parameters:
- DATA_W, 19: signed two's-complement element width.
- LANES, 1: channels per input beat (1, 2, 4, 8).
- MAX_CH, 1024: maximum supported Channel_Nums.
- MAX_TOK, 2^20-1: maximum supported Token_Nums.

Ports:
- clk  in  1  — single clock.
- reset  in  1  — synchronous, active-high.
- start  in  1  — one-cycle pulse; latches config when IDLE.
- Channel_Nums  in  $clog2(MAX_CH+1)  — channels per token.
- Token_Nums  in  $clog2(MAX_TOK+1)  — tokens per frame.
- sData  in  LANES*DATA_W  — lane i occupies bits [i*DATA_W +: DATA_W]; lane 0 is the lowest channel.
- sValid  in  1  — input beat valid.
- sReady  out  1  — input beat accepted when sValid&&sReady.
- mData_valid  out  1  — statistics valid.
- mData_ready  in  1  — downstream accepts.
- mSum  out  SUM_W = DATA_W+$clog2(MAX_CH)  — signed Σx.
- mSumSq  out  SQ_W = 2*DATA_W+$clog2(MAX_CH)  — unsigned Σx².
- mLast  out  1  — qualifies the final token's statistics.
- busy  out  1  — high when not IDLE.
- cfg_err  out  1  — one-cycle pulse on a rejected start.

## Operation
- FSM states: IDLE, ACC, DRAIN.
- IDLE: sReady=0. On start:
  - Config valid (Channel_Nums ≠ 0, Channel_Nums ≤ MAX_CH, Channel_Nums % LANES == 0, Token_Nums ≠ 0): latch beats_per_tok = Channel_Nums/LANES and Token_Nums; clear counters and accumulators; go to ACC.
  - Config invalid: pulse cfg_err; stay in IDLE.
- ACC, per accepted beat:
  - Compute beat_sum (sign-extended lane sum) and beat_sq (sum of lane squares, each square unsigned, 2*DATA_W bits).
  - Not the token's last beat: acc_sum += beat_sum; acc_sq += beat_sq; beat_cnt++.
  - Token's last beat: mSum <= acc_sum+beat_sum; mSumSq <= acc_sq+beat_sq; mData_valid <= 1; accumulators and beat_cnt clear to 0; tok_cnt++. If this is the final token, mLast <= 1 and go to DRAIN.
- DRAIN: sReady=0. On mData_valid&&mData_ready, go to IDLE.
- Arithmetic:
  - Full precision throughout; no saturation.
  - SUM_W and SQ_W are sized so MAX_CH worst-case inputs cannot overflow. The most negative input (-2^(DATA_W-1)) squared must be exact.
- start while busy: ignored, no cfg_err.
- reset mid-frame: every register returns to its reset value; the partial token is discarded; no output.

## Timing
- Reset values: sReady=0, mData_valid=0, mSum=0, mSumSq=0, mLast=0, busy=0, cfg_err=0.
- Config latch: start in cycle t → busy=1 and sReady can be 1 from t+1.
- Latency: last beat of a token accepted at edge t → mData_valid=1 from t+1, one register stage.
- Throughput: one beat/cycle while unstalled.
- sReady = (state==ACC) && (!mData_valid || mData_ready). It is combinational from mData_ready, so a held result stalls input and no result is ever overwritten.
- mData_valid, mSum, mSumSq and mLast are stable while mData_valid && !mData_ready. mData_valid falls the cycle after the handshake unless a new result is loaded on that same edge.
- Back-to-back case: a final beat and an output handshake on the same edge load the new result; mData_valid stays 1.
- sValid is ignored whenever sReady=0; no data is consumed.

## Structure
- Shared package ln_pkg:
  - SUM_W and SQ_W width functions.
  - State enum {IDLE, ACC, DRAIN}.
  - Config-check function (cfg_ok).
- One sub-module, ln_lane_reduce: combinational LANES-wide sign-extended sum and square-sum tree. Parameters DATA_W and LANES; outputs beat_sum and beat_sq.
- Top holds the FSM, counters, accumulators and output register.

## Test plan
- DATA_W=19, LANES=1, Channel_Nums=768, Token_Nums=197, sReady-continuous sink, all inputs +1 → 197 outputs with mSum=768 and mSumSq=768; mLast only on the 197th; busy drops after its handshake.
- LANES=4, Channel_Nums=8, Token_Nums=2, beats {1,-2,3,-4},{5,-6,7,-8} per token → mSum=-4, mSumSq=204 for each token; output appears one cycle after the 2nd beat.
- Worst case: LANES=1, Channel_Nums=MAX_CH=1024, all inputs -2^18 → mSum=-2^28, mSumSq=2^46, no wrap.
- Backpressure: mData_ready held 0 for 10 cycles after the first result → sReady=0 for those cycles, outputs stable, no input beat lost; the result after release equals the golden model.
- Config errors: start with Channel_Nums=6 at LANES=4, then Channel_Nums=0, then Token_Nums=0 → a one-cycle cfg_err each, busy stays 0, sReady stays 0.
- Reset after 100 accepted beats of a token, then restart with Channel_Nums=4, Token_Nums=1, inputs 2,2,2,2 → the first result is mSum=8, mSumSq=16 with mLast=1; no residue from the aborted token.
